// File: rtl/stream_register_slice.sv
// stream_register_slice: two-entry valid/ready register slice (main + skid).
// Every handshake output and the payload come straight from flops; one transfer per cycle.
`default_nettype none

module stream_register_slice #(
  parameter int DataWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DataWidth-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DataWidth-1:0] out_data,
  output logic [1:0]           occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 ready_q;
  logic [DataWidth-1:0] main_q;
  logic [DataWidth-1:0] skid_q;
  logic                 in_fire;
  logic                 out_fire;
  logic                 load_main_in;
  logic                 load_main_skid;
  logic                 load_skid;

  assign in_fire   = in_valid & ready_q;
  assign out_fire  = out_valid & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign occupancy = (state == FULL) ? 2'd2 : ((state == ONE) ? 2'd1 : 2'd0);

  // Ready is its own flop so it can sit low through reset and rise on the first clean edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next != FULL);
    end
  end

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_next   = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          state_next = FULL;
          load_skid  = 1'b1;
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_next     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_register_slice.sv
// tb_stream_register_slice: table vectors, directed corner sequences and a
// queue-model random stress run for stream_register_slice.
`default_nettype none

module tb_stream_register_slice;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [1:0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  stream_register_slice #(.DataWidth(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic       ordy;
    logic [7:0] d;
    logic       eov;
    logic       eir;
    logic [1:0] eocc;
    logic [7:0] edat;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic ir,
                         input logic [1:0] occ, input logic [7:0] dat);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, ir});
    chk({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, occ});
    chk({tag, ".out_data"},  {24'd0, out_data},  {24'd0, dat});
  endtask

  initial begin
    // Model state for the random run
    logic [7:0] q[$];
    logic       m_ir;
    logic       fin;
    logic       fout;
    logic       stall;
    logic [7:0] held;

    // Vector records: inputs applied before an edge, expected outputs after it
    tbl[0]  = '{1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 2'd0, 8'h00}; // in_ready still low: not taken
    tbl[1]  = '{1'b1, 1'b0, 8'hA1, 1'b1, 1'b1, 2'd1, 8'hA1};
    tbl[2]  = '{1'b1, 1'b0, 8'hA2, 1'b1, 1'b0, 2'd2, 8'hA1};
    tbl[3]  = '{1'b1, 1'b0, 8'hA3, 1'b1, 1'b0, 2'd2, 8'hA1};
    tbl[4]  = '{1'b1, 1'b0, 8'hA3, 1'b1, 1'b0, 2'd2, 8'hA1};
    tbl[5]  = '{1'b1, 1'b0, 8'hA3, 1'b1, 1'b0, 2'd2, 8'hA1};
    tbl[6]  = '{1'b1, 1'b0, 8'hA3, 1'b1, 1'b0, 2'd2, 8'hA1};
    tbl[7]  = '{1'b1, 1'b0, 8'hA3, 1'b1, 1'b0, 2'd2, 8'hA1};
    tbl[8]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 2'd1, 8'hA2};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 2'd0, 8'hA2};
    tbl[10] = '{1'b0, 1'b0, 8'h77, 1'b0, 1'b1, 2'd0, 8'hA2};
    tbl[11] = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 2'd1, 8'h11};
    tbl[12] = '{1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 2'd1, 8'h22};
    tbl[13] = '{1'b0, 1'b0, 8'h99, 1'b1, 1'b1, 2'd1, 8'h22};
    tbl[14] = '{1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 2'd1, 8'h33};

    // Reset held three cycles
    repeat (3) cyc();
    chk_all("reset", 1'b0, 1'b0, 2'd0, 8'h00);
    rst = 1'b0;
    #1;
    chk("release.in_ready", {31'd0, in_ready}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      in_data   = tbl[i].d;
      cyc();
      chk_all($sformatf("vec%0d", i), tbl[i].eov, tbl[i].eir, tbl[i].eocc, tbl[i].edat);
    end

    // Drain to EMPTY, then stream 0x01..0x10 back to back
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("pre_stream.occupancy", {30'd0, occupancy}, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      cyc();
      chk_all($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, 8'(i));
    end
    in_valid = 1'b0;
    cyc();
    chk_all("stream_end", 1'b0, 1'b1, 2'd0, 8'h10);

    // Fill with B1, B2 then reset asynchronously mid-cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hB1;
    cyc();
    in_data = 8'hB2;
    cyc();
    chk_all("full_b", 1'b1, 1'b0, 2'd2, 8'hB1);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 2'd0, 8'h00);
    cyc();
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk_all("post_rst", 1'b0, 1'b1, 2'd0, 8'h00);
    in_valid = 1'b1;
    in_data  = 8'hC0;
    cyc();
    chk_all("c0_first", 1'b1, 1'b1, 2'd1, 8'hC0);
    in_valid = 1'b0;
    cyc();
    chk("c0_only.out_valid", {31'd0, out_valid}, 32'd0);

    // Random stress against a FIFO-of-depth-two model
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    q.delete();
    m_ir  = 1'b0;
    stall = 1'b0;
    held  = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      fin  = in_valid && m_ir;
      fout = out_ready && (q.size() > 0);
      stall = (q.size() > 0) && !out_ready;
      held  = out_data;
      if (fout) begin
        chk("sb.data", {24'd0, out_data}, {24'd0, q[0]});
        void'(q.pop_front());
      end
      if (fin) q.push_back(in_data);
      cyc();
      m_ir = (q.size() < 2);
      chk("rnd.out_valid", {31'd0, out_valid}, {31'd0, (q.size() > 0)});
      chk("rnd.in_ready",  {31'd0, in_ready},  {31'd0, m_ir});
      chk("rnd.occupancy", {30'd0, occupancy}, 32'(q.size()));
      if (q.size() > 0) chk("rnd.out_data", {24'd0, out_data}, {24'd0, q[0]});
      if (stall) chk("rnd.stable", {24'd0, out_data}, {24'd0, held});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_register_slice.md
# stream_register_slice

Full-throughput two-entry register slice for a valid/ready stream carrying a data word. It sits directly upstream of `stream_split`. `stream_split` drives its `in_ready` as the combinational AND of every branch's ready, and this slice cuts that path. With the slice in place, every upstream-facing and downstream-facing handshake output comes straight from a flop. It sustains one transfer per cycle with one cycle of latency.

## Interface
- `DataWidth`, default 8: width of the payload word in bits.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset; asynchronous, active-high.
- `in_valid`  input  1  upstream word present.
- `in_ready`  output  1  slice can accept a word; registered.
- `in_data`  input  DataWidth  upstream payload.
- `out_valid`  output  1  slice presents a word; registered.
- `out_ready`  input  1  downstream (`stream_split` `in_ready`) accepts.
- `out_data`  output  DataWidth  payload presented downstream; registered.
- `occupancy`  output  2  words currently held: 0, 1 or 2; registered.

## Operation
- A transfer occurs on a port when its valid and ready are both high at a rising `clk` edge.
- Storage is a main register (drives `out_data`) and a skid register. Words leave in arrival order. No word is dropped or duplicated.
- States:
  - EMPTY: `occupancy`=0, `out_valid`=0, `in_ready`=1.
  - ONE: `occupancy`=1, `out_valid`=1, `in_ready`=1.
  - FULL: `occupancy`=2, `out_valid`=1, `in_ready`=0.
- Transitions (in = input transfer, out = output transfer):
  - EMPTY + in → ONE; the word loads into the main register.
  - ONE + in + out → ONE; main loads `in_data`.
  - ONE + in, no out → FULL; the word goes to the skid register.
  - ONE + out, no in → EMPTY.
  - FULL + out → ONE; skid moves to main. No input transfer is possible in FULL because `in_ready`=0.
  - No transfers → hold state and contents.
- `in_ready`, `out_valid` and `occupancy` are decoded from state flops, never from same-cycle inputs. No combinational path exists from `out_ready` or `in_valid` to any output.
- While `out_valid`=1 and `out_ready`=0, `out_data` holds stable.
- `in_valid` may drop at any time, and `in_data` is ignored when no input transfer occurs. `out_ready` may toggle freely.
- `in_valid` or `out_ready` arriving in EMPTY or FULL with no matching transfer: no effect.

## Timing
- Reset values while `rst`=1, asynchronous:
  - state EMPTY, `occupancy`=0, `out_valid`=0, `out_data`=0.
  - `in_ready`=0, so nothing is accepted during reset.
- `in_ready` rises at the first rising edge of `clk` with `rst` low, then follows state.
- Latency: a word accepted at edge N is presented on `out_valid`/`out_data` after edge N and can transfer out at edge N+1 at the earliest.
- Throughput: with `out_ready` held at 1, one word per cycle indefinitely; `in_ready` never drops.
- `in_ready` falls the cycle after a back-pressure stall fills the skid. It rises the cycle after the first output transfer from FULL.
- Reset asserted mid-stream, in any state: contents are discarded and all outputs take their reset values immediately. No partial word is emitted afterwards.
- The skid register is never observable on `out_data` except through a FULL→ONE move.

## Test plan
- Reset then idle: `rst` high for 3 cycles → `out_valid`=0, `in_ready`=0, `occupancy`=0, `out_data`=0. After release, `in_ready`=1 from the next edge.
- Streaming: drive 0x01..0x10 on consecutive cycles with `out_ready`=1 → outputs 0x01..0x10 in order, one per cycle starting one cycle after the first input. `in_ready` stays 1 and `occupancy` stays 1 throughout.
- Back-pressure fill: `out_ready`=0 and send 0xA1, 0xA2 → `occupancy`=2 and `in_ready`=0. `out_data`=0xA1 stays stable for 5 stall cycles. An extra `in_valid` with 0xA3 is not accepted.
- Drain from FULL: from the previous state, set `out_ready`=1 → 0xA1 then 0xA2 transfer out. `in_ready`=1 from the cycle after 0xA1 leaves, and `occupancy` goes 2→1→0.
- Random stress: 10,000 cycles with random `in_valid` and `out_ready`, each 50% → a scoreboard sees exact in-order match with no loss or duplication. `out_data` never changes while `out_valid`=1 and `out_ready`=0.
- Mid-stream reset: assert `rst` in FULL holding 0xB1, 0xB2 → `out_valid`=0 immediately. After release, 0xB1 and 0xB2 are never emitted and the next input 0xC0 appears first.
